// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Conditions four raw, bouncing, active-low pushbuttons into clean events.
// Each key has its own channel with no shared state. A channel contains a
// two-flop synchronizer, a debounce/auto-repeat FSM with one shared counter,
// and registered outputs.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples needed to accept
//                     a level change (>= 2)
//   REPEAT_EN       : non-zero enables auto-repeat press pulses while held
//   REPEAT_DELAY    : cycles spent in HELD before the first repeat pulse (>= 1)
//   REPEAT_PERIOD   : cycles between subsequent repeat pulses (>= 1)
//
// Ports
//   clk           : single clock, all flops on posedge
//   reset         : asynchronous, active-high
//   KEY[3:0]      : raw pushbuttons, active-low (0 = pressed), asynchronous
//   pressed[3:0]  : debounced key level, active-high
//   press[3:0]    : one-cycle pulse per accepted press and per auto-repeat
//   release_pulse : one-cycle pulse per accepted release ("release" is a
//                   reserved word in SystemVerilog, hence the longer name)
//
// Latency: a key first captured low by the synchronizer at edge N (and held
// low) raises press/pressed on edge N+DEBOUNCE_CYCLES+2. Releases behave the
// same way.
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] KEY,
    output logic [3:0] pressed,
    output logic [3:0] press,
    output logic [3:0] release_pulse
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_CNT + 1);

    // Terminal counts: the counter is compared before it increments, so
    // "N samples" ends when the counter reads N-1.
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_UP,
        ST_ARM_DOWN,
        ST_HELD,
        ST_REPEAT,
        ST_ARM_UP
    } state_t;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            logic          sync1_q;
            logic          sync2_q;
            state_t        state_q,   state_d;
            logic [CW-1:0] cnt_q,     cnt_d;
            logic          pressed_q, pressed_d;
            logic          press_q,   press_d;
            logic          rel_q,     rel_d;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    // Synchronizer resets to "released" so the first edge
                    // after reset cannot see a phantom press.
                    sync1_q   <= 1'b1;
                    sync2_q   <= 1'b1;
                    state_q   <= ST_UP;
                    cnt_q     <= '0;
                    pressed_q <= 1'b0;
                    press_q   <= 1'b0;
                    rel_q     <= 1'b0;
                end else begin
                    sync1_q   <= KEY[gi];
                    sync2_q   <= sync1_q;
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    pressed_q <= pressed_d;
                    press_q   <= press_d;
                    rel_q     <= rel_d;
                end
            end

            // sync2_q is the synchronized raw level: 0 = key down.
            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                pressed_d = pressed_q;
                press_d   = 1'b0;
                rel_d     = 1'b0;
                case (state_q)
                    ST_UP: begin
                        cnt_d = '0;
                        if (!sync2_q) begin
                            state_d = ST_ARM_DOWN;
                        end
                    end
                    ST_ARM_DOWN: begin
                        if (sync2_q) begin
                            // Bounce: abandon the attempt silently.
                            state_d = ST_UP;
                            cnt_d   = '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d   = ST_HELD;
                            cnt_d     = '0;
                            pressed_d = 1'b1;
                            press_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    ST_HELD: begin
                        if (sync2_q) begin
                            state_d = ST_ARM_UP;
                            cnt_d   = '0;
                        end else if (REPEAT_EN != 0) begin
                            if (cnt_q == DLY_LAST) begin
                                state_d = ST_REPEAT;
                                cnt_d   = '0;
                                press_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                        // Without auto-repeat the counter simply idles.
                    end
                    ST_REPEAT: begin
                        if (sync2_q) begin
                            state_d = ST_ARM_UP;
                            cnt_d   = '0;
                        end else if (cnt_q == PER_LAST) begin
                            cnt_d   = '0;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    ST_ARM_UP: begin
                        if (!sync2_q) begin
                            // Release bounce: back to HELD, repeat delay
                            // starts over, no pulse, level stays asserted.
                            state_d = ST_HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_d   = ST_UP;
                            cnt_d     = '0;
                            pressed_d = 1'b0;
                            rel_d     = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_d   = ST_UP;
                        cnt_d     = '0;
                        pressed_d = 1'b0;
                    end
                endcase
            end

            assign pressed[gi]       = pressed_q;
            assign press[gi]         = press_q;
            assign release_pulse[gi] = rel_q;
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, REPEAT_EN=1. Every clock edge after a reset is numbered
// from 0. Each step drives KEY for the coming edge and pushes the expected
// outputs for that edge onto a scoreboard queue. After the edge, the step
// pops the entry and compares it with the DUT outputs. The expected
// timelines come straight from the latency rules:
// press at N+6, repeats at +10 and then every 3 cycles, release at M+6.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic [3:0] pressed;
    logic [3:0] press;
    logic [3:0] release_pulse;

    typedef struct packed {
        logic [3:0] press;
        logic [3:0] pressed;
        logic [3:0] rel;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_EN      (1),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .KEY          (KEY),
        .pressed      (pressed),
        .press        (press),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", name, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t x);
        chk({tag, " press"},   press,         x.press);
        chk({tag, " pressed"}, pressed,       x.pressed);
        chk({tag, " release"}, release_pulse, x.rel);
    endtask

    // Drive KEY for one edge, queue the expectation, then check after the edge.
    task automatic step(input string scen, input int e, input logic [3:0] key,
                        input logic [3:0] ep, input logic [3:0] epd, input logic [3:0] er);
        exp_t x;
        KEY       = key;
        x.press   = ep;
        x.pressed = epd;
        x.rel     = er;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", scen);
        end else begin
            x = sb_q.pop_front();
            chk_all($sformatf("%s e%0d", scen, e), x);
        end
        $display("%s edge %0d KEY=%b press=%b pressed=%b release=%b",
                 scen, e, key, press, pressed, release_pulse);
    endtask

    task automatic do_reset(input string scen);
        exp_t z;
        z = '0;
        KEY   = 4'b1111;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all({scen, " reset"}, z);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] k;
        logic [3:0] ep;
        logic [3:0] epd;
        logic [3:0] er;
        exp_t z;
        z     = '0;
        reset = 1'b1;
        KEY   = 4'b1111;

        // Clean press on key 0 with auto-repeat.
        do_reset("clean");
        for (int e = 0; e <= 25; e++) begin
            ep  = (e == 6 || (e >= 16 && (e - 16) % 3 == 0)) ? 4'b0001 : 4'b0000;
            epd = (e >= 6) ? 4'b0001 : 4'b0000;
            step("clean", e, 4'b1110, ep, epd, 4'b0000);
        end

        // Bounce on key 1: 3-cycle runs never reach 4 stable samples.
        do_reset("bounce");
        for (int e = 0; e < 40; e++) begin
            k    = 4'b1111;
            k[1] = (e < 30) ? (((e / 3) % 2) != 0) : 1'b1;
            step("bounce", e, k, 4'b0000, 4'b0000, 4'b0000);
        end

        // Key 2: press, 2-cycle release, 2-cycle re-press glitch, final release at M=12.
        do_reset("release");
        for (int e = 0; e <= 23; e++) begin
            k    = 4'b1111;
            k[2] = (e <= 7) ? 1'b0 : (e <= 9) ? 1'b1 : (e <= 11) ? 1'b0 : 1'b1;
            ep   = (e == 6) ? 4'b0100 : 4'b0000;
            epd  = (e >= 6 && e < 18) ? 4'b0100 : 4'b0000;
            er   = (e == 18) ? 4'b0100 : 4'b0000;
            step("release", e, k, ep, epd, er);
        end

        // All four keys at once.
        do_reset("simul");
        for (int e = 0; e <= 22; e++) begin
            ep  = (e == 6 || (e >= 16 && (e - 16) % 3 == 0)) ? 4'b1111 : 4'b0000;
            epd = (e >= 6) ? 4'b1111 : 4'b0000;
            step("simul", e, 4'b0000, ep, epd, 4'b0000);
        end

        // Reset while key 3 is held.
        do_reset("rsthold");
        for (int e = 0; e <= 19; e++) begin
            ep  = (e == 6 || e == 16 || e == 19) ? 4'b1000 : 4'b0000;
            epd = (e >= 6) ? 4'b1000 : 4'b0000;
            step("rsthold", e, 4'b0111, ep, epd, 4'b0000);
        end
        #1;
        reset = 1'b1;
        #1;
        chk_all("rsthold async", z);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("rsthold inreset%0d", i), z);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            ep  = (e == 6) ? 4'b1000 : 4'b0000;
            epd = (e >= 6) ? 4'b1000 : 4'b0000;
            step("rstafter", e, 4'b0111, ep, epd, 4'b0000);
        end

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter REPEAT_EN, default 1, enables auto-repeat press pulses while a key is held.
REQ-003 Parameter REPEAT_DELAY, default 25000000, is the hold time in cycles from accepted press to first repeat pulse; legal range >= 1.
REQ-004 Parameter REPEAT_PERIOD, default 5000000, is the cycles between subsequent repeat pulses; legal range >= 1.
REQ-005 clk  input  1  single clock for all logic; all registers clock on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 KEY  input  4  raw pushbuttons, active-low (0 = pressed), asynchronous to clk, bouncing.
REQ-008 pressed  output  4  debounced key level, active-high (1 = held).
REQ-009 press  output  4  one-cycle pulse per accepted press and per auto-repeat; drives the memory-editor controller.
REQ-010 release  output  4  one-cycle pulse per accepted release.

Function
REQ-011 Each KEY bit SHALL pass through its own two-flop synchronizer before any other logic; synchronizer flops reset to 1 (released).
REQ-012 The four keys SHALL be processed by four independent, identical channels with no shared state; simultaneous events on several keys SHALL produce same-cycle pulses on each.
REQ-013 Each channel SHALL implement FSM states UP, ARM_DOWN, HELD, REPEAT, ARM_UP with one counter wide enough for max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
REQ-014 UP: synchronized sample 0 -> ARM_DOWN with counter restarted; otherwise stay.
REQ-015 ARM_DOWN: sample 1 before DEBOUNCE_CYCLES consecutive 0 samples -> UP, no output change (bounce rejected); DEBOUNCE_CYCLES consecutive 0 samples -> HELD, pressed=1, press pulse, counter cleared.
REQ-016 Latency: if KEY[i] is first sampled 0 at edge N and stays 0, press[i] and pressed[i] SHALL rise on edge N+DEBOUNCE_CYCLES+2; press[i] SHALL fall on the next edge.
REQ-017 HELD: sample 1 -> ARM_UP; with REPEAT_EN=1, after REPEAT_DELAY cycles in HELD, press pulses once and -> REPEAT with counter cleared; with REPEAT_EN=0, stays in HELD.
REQ-018 REPEAT: sample 1 -> ARM_UP; every REPEAT_PERIOD cycles, press pulses once (counter wraps to 0, no saturation or overflow).
REQ-019 ARM_UP: sample 0 before DEBOUNCE_CYCLES consecutive 1 samples -> HELD with counter cleared (repeat delay restarts), no pulse, pressed stays 1; DEBOUNCE_CYCLES consecutive 1 samples -> UP, pressed=0, release pulse.
REQ-020 Release latency SHALL mirror REQ-016: release rises on edge M+DEBOUNCE_CYCLES+2, where M is the first edge sampling KEY=1 continuously.
REQ-021 press and release SHALL never be asserted in the same cycle for the same key; at most one press pulse per cycle per key.
REQ-022 All outputs SHALL be registered (no combinational path from KEY to any output).

Reset
REQ-023 While reset=1: all states UP, counters 0, synchronizers 1, pressed=0, press=0, release=0, asserted asynchronously.
REQ-024 Reset mid-operation SHALL produce no release pulse; a key still held after reset deasserts SHALL be re-debounced from UP and yield a fresh press per REQ-016.
REQ-025 First posedge after reset deassertion SHALL treat the synchronizers as holding 1; no spurious pulses.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1)
REQ-026 Clean press: KEY=4'b1110 from edge 0, held -> press=4'b0001 only on edge 6, pressed[0]=1 from edge 6; repeat press pulses on edges 16, 19, 22.
REQ-027 Bounce: KEY[1] toggles 0/1 with run lengths of 3 cycles for 30 cycles, then 1 -> press, pressed, release stay 0 throughout.
REQ-028 Release: from HELD, KEY[2]=1 from edge M -> release[2] pulses on edge M+6, pressed[2]=0 from M+6; a 2-cycle 0 glitch inside ARM_UP returns to HELD with no release.
REQ-029 Simultaneous: KEY=4'b0000 from edge 0 -> press=4'b1111 on edge 6 in one cycle, independent repeats thereafter.
REQ-030 Reset mid-hold: reset pulsed at edge 20 with KEY[3]=0 held -> all outputs 0 immediately, no release; after deassertion at edge R, press[3] on edge R+6.
